// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface mult_div_unit_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  issue_valid;
    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [DATA_WIDTH-1:0] rs_val;
    logic [DATA_WIDTH-1:0] rt_val;
    logic                  stall;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] mf_result;
    logic                  mf_valid;

    modport master (
        output issue_valid, opcode, funct, rs_val, rt_val,
        input  stall, busy, done, mf_result, mf_valid
    );

    modport slave (
        input  issue_valid, opcode, funct, rs_val, rt_val,
        output stall, busy, done, mf_result, mf_valid
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO: one-bit-per-cycle shift-add multiplier and
// restoring divider, with pipeline stall generation while an operation is in flight.
module mult_div_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    mult_div_unit_if.slave  bus
);
    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     hi_q, lo_q, a_q;
    logic [2*W-1:0]   p_q, p_step;
    logic [CW-1:0]    cnt_q;
    logic             negq_q, negr_q, is_div_q, dz_q, busy_q, done_q;

    logic             is_r, op_mul, op_div, op_mfhi, op_mthi, op_mflo, op_mtlo, hit, accept;
    logic             rs_neg, rt_neg;
    logic [W-1:0]     rs_abs, rt_abs, res_hi, res_lo, quot, rem;
    logic [W:0]       sum, trial, diff;
    logic [2*W-1:0]   prod;

    always_comb begin
        is_r    = bus.issue_valid && (bus.opcode == 6'h00);
        op_mul  = is_r && (bus.funct == 6'h18 || bus.funct == 6'h19);
        op_div  = is_r && (bus.funct == 6'h1A || bus.funct == 6'h1B);
        op_mfhi = is_r && (bus.funct == 6'h10);
        op_mthi = is_r && (bus.funct == 6'h11);
        op_mflo = is_r && (bus.funct == 6'h12);
        op_mtlo = is_r && (bus.funct == 6'h13);
        hit     = op_mul || op_div || op_mfhi || op_mthi || op_mflo || op_mtlo;
        accept  = hit && !busy_q;
        // funct[0] clear selects the signed variant of MULT/DIV
        rs_neg  = !bus.funct[0] && bus.rs_val[W-1];
        rt_neg  = !bus.funct[0] && bus.rt_val[W-1];
        rs_abs  = rs_neg ? -bus.rs_val : bus.rs_val;
        rt_abs  = rt_neg ? -bus.rt_val : bus.rt_val;
    end

    // Shared datapath: p_q is {partial product} for MUL or {remainder, quotient} for DIV.
    always_comb begin
        sum   = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, a_q} : '0);
        trial = p_q[2*W-1:W-1];
        diff  = trial - {1'b0, a_q};
        if (state_q == StMul) begin
            p_step = {sum, p_q[W-1:1]};
        end else if (diff[W]) begin
            p_step = {trial[W-1:0], p_q[W-2:0], 1'b0};
        end else begin
            p_step = {diff[W-1:0], p_q[W-2:0], 1'b1};
        end
        prod = negq_q ? -p_q : p_q;
        quot = p_q[W-1:0];
        rem  = p_q[2*W-1:W];
        if (is_div_q) begin
            res_lo = dz_q ? '1 : (negq_q ? -quot : quot);
            res_hi = negr_q ? -rem : rem;
        end else begin
            res_lo = prod[W-1:0];
            res_hi = prod[2*W-1:W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_d == StFix);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept && op_mul) state_d = StMul;
                else if (accept && op_div) state_d = StDiv;
            end
            StMul, StDiv: if (cnt_q == CW'(W - 1)) state_d = StFix;
            StFix: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.stall     = hit && busy_q;
        bus.mf_valid  = (op_mfhi || op_mflo) && !busy_q;
        bus.mf_result = op_mfhi ? hi_q : (op_mflo ? lo_q : '0);
        bus.busy      = busy_q;
        bus.done      = done_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q     <= '0;
            lo_q     <= '0;
            a_q      <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept && (op_mul || op_div)) begin
                        a_q      <= op_mul ? rs_abs : rt_abs;
                        p_q      <= {{W{1'b0}}, (op_mul ? rt_abs : rs_abs)};
                        cnt_q    <= '0;
                        negq_q   <= rs_neg ^ rt_neg;
                        negr_q   <= rs_neg;
                        is_div_q <= op_div;
                        dz_q     <= op_div && (bus.rt_val == '0);
                    end
                    if (accept && op_mthi) hi_q <= bus.rs_val;
                    if (accept && op_mtlo) lo_q <= bus.rs_val;
                end
                StMul, StDiv: begin
                    p_q   <= p_step;
                    cnt_q <= cnt_q + CW'(1);
                end
                StFix: begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: table of MUL/DIV vectors plus hand sequences for stall,
// reset-abort and MTHI/MTLO behaviour.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    mult_div_unit_if #(.DATA_WIDTH(32)) bus ();

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] f,
                         input logic [31:0] rs, input logic [31:0] rt);
        bus.issue_valid = v;
        bus.opcode      = op;
        bus.funct       = f;
        bus.rs_val      = rs;
        bus.rt_val      = rt;
    endtask

    // Issue a MUL/DIV, then count busy cycles and done pulses until busy falls.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] rs,
                          input logic [31:0] rt);
        int nb = 0;
        int nd = 0;
        drive(1'b1, 6'h00, f, rs, rt);
        @(negedge clk);
        check({tag, " issue stall"}, {31'b0, bus.stall}, 32'd0);
        tick();
        drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.done) nd++;
            if (!bus.busy) break;
            nb++;
        end
        check({tag, " busy cycles"}, nb, 32'd33);
        check({tag, " done pulses"}, nd, 32'd1);
        tick();
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
        drive(1'b1, 6'h00, 6'h10, 32'h0, 32'h0);
        @(negedge clk);
        check({tag, " MFHI valid"}, {31'b0, bus.mf_valid}, 32'd1);
        check({tag, " HI"}, bus.mf_result, ehi);
        tick();
        drive(1'b1, 6'h00, 6'h12, 32'h0, 32'h0);
        @(negedge clk);
        check({tag, " MFLO valid"}, {31'b0, bus.mf_valid}, 32'd1);
        check({tag, " LO"}, bus.mf_result, elo);
        tick();
        drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
    endtask

    initial begin
        int nst;
        logic last_done;
        vecs[0] = '{6'h18, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{6'h18, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[3] = '{6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4] = '{6'h1B, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vecs[5] = '{6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6] = '{6'h1A, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[7] = '{6'h1B, 32'h00000100, 32'h00000007, 32'h00000004, 32'h00000024};
        vecs[8] = '{6'h19, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[9] = '{6'h1A, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};

        drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
        #2;
        check("reset busy", {31'b0, bus.busy}, 32'd0);
        check("reset done", {31'b0, bus.done}, 32'd0);
        check("reset stall", {31'b0, bus.stall}, 32'd0);
        check("reset mf_valid", {31'b0, bus.mf_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        read_hilo("reset", 32'h0, 32'h0);

        // Non-zero opcode and unknown funct must be ignored.
        drive(1'b1, 6'h23, 6'h18, 32'h5, 32'h6);
        @(negedge clk);
        check("bad opcode stall", {31'b0, bus.stall}, 32'd0);
        tick();
        drive(1'b1, 6'h00, 6'h20, 32'h5, 32'h6);
        @(negedge clk);
        check("bad opcode busy", {31'b0, bus.busy}, 32'd0);
        tick();
        drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
        @(negedge clk);
        check("bad funct busy", {31'b0, bus.busy}, 32'd0);
        tick();

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].funct, vecs[i].rs, vecs[i].rt);
            read_hilo($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);
        end

        // MFLO presented from the 5th cycle of a MULT 6*7 stalls through FIX.
        drive(1'b1, 6'h00, 6'h18, 32'd6, 32'd7);
        tick();
        drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
        repeat (4) tick();
        drive(1'b1, 6'h00, 6'h12, 32'h0, 32'h0);
        nst = 0;
        last_done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!bus.stall) break;
            if (bus.mf_valid) check("mf_valid during stall", 32'd1, 32'd0);
            last_done = bus.done;
            nst++;
            tick();
        end
        check("mflo stall cycles", nst, 32'd29);
        check("done in last stall", {31'b0, last_done}, 32'd1);
        check("mflo after fix valid", {31'b0, bus.mf_valid}, 32'd1);
        check("mflo after fix data", bus.mf_result, 32'h0000002A);
        tick();

        // Reset during DIV iteration 10 aborts; HI/LO return to zero.
        drive(1'b1, 6'h00, 6'h11, 32'h00005555, 32'h0);
        tick();
        drive(1'b1, 6'h00, 6'h1A, 32'h00000064, 32'h00000003);
        tick();
        drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        check("async reset busy", {31'b0, bus.busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        drive(1'b1, 6'h00, 6'h10, 32'h0, 32'h0);
        @(negedge clk);
        check("post-reset MFHI stall", {31'b0, bus.stall}, 32'd0);
        tick();
        read_hilo("post-reset", 32'h0, 32'h0);

        // MTHI while idle, then MFHI.
        drive(1'b1, 6'h00, 6'h11, 32'h00001234, 32'h0);
        tick();
        drive(1'b1, 6'h00, 6'h10, 32'h0, 32'h0);
        @(negedge clk);
        check("mthi readback", bus.mf_result, 32'h00001234);
        tick();

        // MTLO while busy stalls and must not write LO.
        drive(1'b1, 6'h00, 6'h19, 32'd3, 32'd5);
        tick();
        drive(1'b1, 6'h00, 6'h13, 32'h00009999, 32'h0);
        @(negedge clk);
        check("mtlo busy stall", {31'b0, bus.stall}, 32'd1);
        tick();
        drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        tick();
        read_hilo("mtlo blocked", 32'h0, 32'h0000000F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end
endmodule
